// File: rtl/uart_tx_engine_if.sv
// Write/status bundle between the APB UART slave (master side) and the TX engine (slave side).
// Carries the push strobe, the byte, the error clear and the registered FIFO flags.
interface uart_tx_engine_if;
  logic       wr_uart;
  logic [7:0] wr_data;
  logic       err_clr;
  logic       tx_fifo_full;
  logic       tx_fifo_empty;
  logic       tx_fifo_err;

  modport master (
    output wr_uart, wr_data, err_clr,
    input  tx_fifo_full, tx_fifo_empty, tx_fifo_err
  );

  modport slave (
    input  wr_uart, wr_data, err_clr,
    output tx_fifo_full, tx_fifo_empty, tx_fifo_err
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding a start/8-data/parity/stop serialiser.
// Bit period is chosen per frame from four divisors; tx_line and tx_busy are registered together.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV0       = 5208,
  parameter int DIV1       = 2604,
  parameter int DIV2       = 868,
  parameter int DIV3       = 434
) (
  input  logic             PCLK_i,
  input  logic             RESET_i,
  input  logic [1:0]       baud_rate,
  input  logic [1:0]       parity_type,
  uart_tx_engine_if.slave  bus,
  output logic             tx_line,
  output logic             tx_busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DIV_MAX = max2(max2(DIV0, DIV1), max2(DIV2, DIV3));
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_FW  = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Counter reload value (DIV-1) for a given baud select.
  function automatic logic [CNT_W-1:0] div_m1(input logic [1:0] sel);
    case (sel)
      2'b00:   div_m1 = CNT_W'(DIV0 - 1);
      2'b01:   div_m1 = CNT_W'(DIV1 - 1);
      2'b10:   div_m1 = CNT_W'(DIV2 - 1);
      default: div_m1 = CNT_W'(DIV3 - 1);
    endcase
  endfunction

  // FIFO storage and control
  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              err_q, err_d;
  logic              push_ok;
  logic              pop;
  logic [7:0]        head;

  // Serialiser
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic              par_en_q, par_en_d;
  logic [1:0]        baud_sel_q, baud_sel_d;
  logic              tx_line_q, tx_line_d;
  logic              tx_busy_q, tx_busy_d;
  logic              bit_done;

  assign head = fifo_mem_q[rd_ptr_q];

  // Overflow check uses the pre-edge count, so a push while full is dropped even if a pop frees a slot.
  always_comb begin
    push_ok  = bus.wr_uart && (count_q != CNT_FW'(FIFO_DEPTH));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    if (bus.wr_uart && !push_ok) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    baud_sel_d = baud_sel_q;
    pop        = 1'b0;
    tx_line_d  = 1'b1;
    tx_busy_d  = (state_q != IDLE);
    bit_done   = (bit_cnt_q == '0);

    case (state_q)
      IDLE: begin
        tx_line_d = 1'b1;
        if (count_q != '0) begin
          pop        = 1'b1;
          shift_d    = head;
          par_bit_d  = (^head) ^ (parity_type == 2'b10);
          par_en_d   = (parity_type == 2'b01) || (parity_type == 2'b10);
          baud_sel_d = baud_rate;
          bit_cnt_d  = div_m1(baud_rate);
          bit_idx_d  = 3'd0;
          state_d    = START;
        end
      end
      START: begin
        tx_line_d = 1'b0;
        if (bit_done) begin
          bit_cnt_d = div_m1(baud_sel_q);
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        tx_line_d = shift_q[0];
        if (bit_done) begin
          bit_cnt_d = div_m1(baud_sel_q);
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      PARITY: begin
        tx_line_d = par_bit_q;
        if (bit_done) begin
          bit_cnt_d = div_m1(baud_sel_q);
          state_d   = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        tx_line_d = 1'b1;
        if (bit_done) begin
          state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: reset applies here only
  always_ff @(posedge PCLK_i) begin
    if (RESET_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_q      <= 1'b0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      par_en_q   <= 1'b0;
      baud_sel_q <= 2'b00;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      par_en_q   <= par_en_d;
      baud_sel_q <= baud_sel_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Datapath state: no reset needed, always written before use
  always_ff @(posedge PCLK_i) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign tx_line           = tx_line_q;
  assign tx_busy           = tx_busy_q;
  assign bus.tx_fifo_full  = full_q;
  assign bus.tx_fifo_empty = empty_q;
  assign bus.tx_fifo_err   = err_q;

endmodule
